// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end.
//   Owns the fetch PC, issues word fetches over a req/ack handshake, buffers
//   returned words and presents them one at a time under valid/ready.
//   A taken PCSrc on a transfer redirects the PC and discards buffered words.
// Optional build macro: FETCH_BUFFER_EN
//   defined   -> 2-entry prefetch FIFO, request while (entries + outstanding) < 2
//   undefined -> single holding slot, request when the slot is empty or is
//                being transferred this cycle
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8
);

`ifdef FETCH_BUFFER_EN
  localparam int   DEPTH       = 2;
  // With a real FIFO the request depends only on occupancy.
  localparam logic HOLD_REFILL = 1'b0;
`else
  localparam int   DEPTH       = 1;
  // A single slot may refill in the very cycle it is handed over.
  localparam logic HOLD_REFILL = 1'b1;
`endif

  localparam logic [1:0] FULL    = 2'(DEPTH);
  localparam logic [1:0] FULL_M1 = 2'(DEPTH - 1);

  // IDLE only exists for the first cycle after reset so that the first
  // request rises one cycle after reset is released.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,   // request high, waiting for ack
    S_HOLD     // buffer full, request low (except same-cycle refill)
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t      state, state_next;
  entry_t      slots      [DEPTH];
  entry_t      slots_next [DEPTH];
  logic [1:0]  count, count_next;
  logic [1:0]  fill_after_pop;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        transfer;
  logic        redirect;
  logic        accept;

  // Handshake events for this cycle.
  assign transfer       = instr_valid & instr_ready;
  assign redirect       = transfer & PCSrc;
  // Data acked in a redirect cycle belongs to the abandoned path.
  assign accept         = imem_req & imem_ack & ~redirect;
  assign fill_after_pop = count - {1'b0, transfer};

  // Presented instruction is always the head of the buffer.
  assign instr_valid = (count != 2'd0);
  assign Instr       = slots[0].instr;
  assign PC          = slots[0].pc;
  assign PCPlus8     = slots[0].pc + 32'd8;
  // Address only moves on an accepted ack or a redirect, so it is stable
  // for the whole life of an ordinary request.
  assign imem_addr   = fetch_pc;

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // FSM next-state and request decode.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (!redirect && imem_ack && (fill_after_pop == FULL_M1))
          state_next = S_HOLD;
      end
      S_HOLD: begin
        imem_req = HOLD_REFILL & transfer;
        if (redirect)
          state_next = S_FETCH;
        else if (transfer && !(HOLD_REFILL && imem_ack))
          state_next = S_FETCH;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Buffer, occupancy and fetch-PC update.
  always_comb begin
    slots_next    = slots;
    count_next    = count;
    fetch_pc_next = fetch_pc;
    if (redirect) begin
      // Flush everything buffered; the stale slot contents are never shown
      // because valid drops with the count.
      count_next    = 2'd0;
      fetch_pc_next = Result & 32'hFFFF_FFFC;
    end else begin
      if (transfer) begin
        for (int i = 0; i < DEPTH - 1; i++) slots_next[i] = slots[i + 1];
      end
      if (accept) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (fill_after_pop == 2'(i)) begin
            slots_next[i].instr = imem_rdata;
            slots_next[i].pc    = fetch_pc;
          end
        end
        // Natural 32-bit wrap takes FFFF_FFFC to 0000_0000.
        fetch_pc_next = fetch_pc + 32'd4;
      end
      count_next = fill_after_pop + {1'b0, accept};
    end
  end

  // Datapath registers.
  // NOTE: the slot storage is reset because the head entry drives Instr/PC
  // directly and those outputs have defined reset values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 2'd0;
      fetch_pc <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i].instr <= 32'h0000_0000;
        slots[i].pc    <= RESET_PC;
      end
    end else begin
      count    <= count_next;
      fetch_pc <= fetch_pc_next;
      slots    <= slots_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit with a queue-based
// scoreboard of fetched words checked every cycle, plus literal checks.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FETCH_BUFFER_EN
  localparam int CAP       = 2;
  localparam int HOLD_ACKS = 1;
  localparam bit T4_ACK    = 1'b1;
`else
  localparam int CAP       = 1;
  localparam int HOLD_ACKS = 0;
  localparam bit T4_ACK    = 1'b0;
`endif

  // Main DUT (RESET_PC = 0) signals.
  logic        reset;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] Instr, PC, PCPlus8, Result;
  logic        instr_valid, instr_ready, PCSrc;

  // Wrap DUT (RESET_PC = FFFF_FFF8) signals.
  logic        req_b, valid_b;
  logic [31:0] addr_b, rdata_b, instr_b, pc_b, pc8_b;

  // Memory model controls.
  int   delay     = 0;
  int   wait_cnt  = 0;
  logic ack_force = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .Instr(Instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCSrc(PCSrc), .Result(Result), .PC(PC), .PCPlus8(PCPlus8)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .reset(reset),
    .imem_req(req_b), .imem_addr(addr_b),
    .imem_ack(req_b), .imem_rdata(rdata_b),
    .Instr(instr_b), .instr_valid(valid_b), .instr_ready(1'b1),
    .PCSrc(1'b0), .Result(32'h0000_0000), .PC(pc_b), .PCPlus8(pc8_b)
  );

  // Memory: word = address ^ E000_0000, ack after 'delay' request cycles.
  assign imem_rdata = imem_addr ^ 32'hE000_0000;
  assign rdata_b    = addr_b ^ 32'hE000_0000;
  assign imem_ack   = ack_force | (imem_req && (wait_cnt >= delay));

  always @(posedge clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: the queue holds every accepted word not yet handed over.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } fetched_t;

  fetched_t    q[$];
  logic [31:0] m_fetch   = 32'h0000_0000;
  bit          m_started = 1'b0;
  bit          m_fresh   = 1'b1;
  int          ack_cnt   = 0;

  always @(negedge clk) begin
    logic exp_req;
    bit   xfer;
    if (q.size() != 0) begin
      check_b("m_valid", instr_valid, 1'b1);
      check("m_instr", Instr, q[0].word);
      check("m_pc", PC, q[0].pc);
      check("m_pc8", PCPlus8, q[0].pc + 32'd8);
    end else begin
      check_b("m_valid", instr_valid, 1'b0);
      if (m_fresh) begin
        check("m_rst_instr", Instr, 32'h0000_0000);
        check("m_rst_pc", PC, 32'h0000_0000);
        check("m_rst_pc8", PCPlus8, 32'h0000_0008);
      end
    end
    if (!m_started)    exp_req = 1'b0;
    else if (CAP == 2) exp_req = (q.size() < 2);
    else               exp_req = (q.size() == 0) || instr_ready;
    check_b("m_req", imem_req, exp_req);
    if (exp_req) check("m_addr", imem_addr, m_fetch);

    if (reset) begin
      q.delete();
      m_fetch   = 32'h0000_0000;
      m_started = 1'b0;
      m_fresh   = 1'b1;
    end else begin
      xfer = (q.size() != 0) && instr_ready;
      if (imem_req && imem_ack) ack_cnt++;
      if (xfer && PCSrc) begin
        q.delete();
        m_fetch = Result & 32'hFFFF_FFFC;
        m_fresh = 1'b0;
      end else begin
        if (xfer) void'(q.pop_front());
        if (exp_req && imem_ack) begin
          q.push_back('{pc: m_fetch, word: m_fetch ^ 32'hE000_0000});
          m_fetch = m_fetch + 32'd4;
          m_fresh = 1'b0;
        end
      end
      m_started = 1'b1;
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    int n;
    int ack_snap;
    bit found;
    reset       = 1'b1;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    Result      = 32'h0;
    repeat (3) step();

    // Cycle 0: reset released, nothing requested yet.
    reset       = 1'b0;
    instr_ready = 1'b1;
    #1;
    check_b("c0_req", imem_req, 1'b0);
    check_b("c0_valid", instr_valid, 1'b0);
    check("c0_pc", PC, 32'h0);
    step();  // cycle 1
    check_b("c1_req", imem_req, 1'b1);
    check("c1_addr", imem_addr, 32'h0);
    step();  // cycle 2
    check_b("c2_valid", instr_valid, 1'b1);
    check("c2_pc", PC, 32'h0);
    check("c2_instr", Instr, 32'hE000_0000);
    check("c2_pc8", PCPlus8, 32'h0000_0008);
    check("wrap_pc0", pc_b, 32'hFFFF_FFF8);
    step();  // cycle 3
    check("c3_pc", PC, 32'h4);
    check("wrap_pc1", pc_b, 32'hFFFF_FFFC);
    check("wrap_pc8", pc8_b, 32'h0000_0004);
    step();  // cycle 4
    check("wrap_pc2", pc_b, 32'h0000_0000);
    check("wrap_instr2", instr_b, 32'hE000_0000);

    // Stall with PC=8 presented; PCSrc without transfer must be ignored.
    ack_snap    = ack_cnt;
    instr_ready = 1'b0;
    PCSrc       = 1'b1;
    Result      = 32'hDEAD_BEEF;
    #1;
    check("c4_pc", PC, 32'h8);
    check("c4_pc8", PCPlus8, 32'h10);
    check("c4_instr", Instr, 32'hE000_0008);
    for (int i = 1; i < 5; i++) begin
      step();
      check_b("hold_valid", instr_valid, 1'b1);
      check("hold_pc", PC, 32'h8);
      check("hold_pc8", PCPlus8, 32'h10);
      check("hold_instr", Instr, 32'hE000_0008);
    end
    step();  // cycle 9
    check("hold_acks", ack_cnt - ack_snap, HOLD_ACKS);

    // Redirect on the transfer of PC=8 to 0x103 -> 0x100.
    instr_ready = 1'b1;
    PCSrc       = 1'b1;
    Result      = 32'h0000_0103;
    #1;
    check("redir_pc", PC, 32'h8);
    step();  // cycle 10
    PCSrc  = 1'b0;
    Result = 32'h0;
    #1;
    check_b("c10_valid", instr_valid, 1'b0);
    check_b("c10_req", imem_req, 1'b1);
    check("c10_addr", imem_addr, 32'h100);
    step();  // cycle 11
    check_b("c11_valid", instr_valid, 1'b1);
    check("c11_pc", PC, 32'h100);
    check("c11_instr", Instr, 32'hE000_0100);

    // Slow memory; redirect lands on the ack cycle (buffered) or while the
    // request is still unacked (single slot).
    instr_ready = 1'b0;
    delay       = 3;
    found       = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (instr_valid && (T4_ACK ? imem_ack : 1'b1)) found = 1'b1;
      else step();
    end
    check_b("t4_align", found, 1'b1);
    instr_ready = 1'b1;
    PCSrc       = 1'b1;
    Result      = 32'h0000_0202;
    step();
    PCSrc  = 1'b0;
    Result = 32'h0;
    #1;
    check_b("t4_valid0", instr_valid, 1'b0);
    check_b("t4_req", imem_req, 1'b1);
    check("t4_addr", imem_addr, 32'h200);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else step();
    end
    check_b("t4_wait", found, 1'b1);
    check("t4_pc", PC, 32'h200);
    check("t4_instr", Instr, 32'hE000_0200);

    // Reset pulsed mid-request with a valid instruction; late ack ignored.
    check_b("t6_busy", imem_req & instr_valid, 1'b1);
    reset = 1'b1;
    step();
    ack_force = 1'b1;
    #1;
    check_b("t6_valid", instr_valid, 1'b0);
    check_b("t6_req", imem_req, 1'b0);
    check("t6_pc", PC, 32'h0);
    check("t6_pc8", PCPlus8, 32'h8);
    check("t6_instr", Instr, 32'h0);
    step();
    reset     = 1'b0;
    ack_force = 1'b0;
    delay     = 0;
    #1;
    n     = 0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (instr_valid) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    check_b("t6_restart", found, 1'b1);
    check("t6_latency", n, 2);
    check("t6_pc_first", PC, 32'h0);
    check("t6_instr_first", Instr, 32'hE000_0000);
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
